// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Two-out-of-three vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: a 2-FF synchroniser followed by
// a small sample register feeding a 2-of-3 majority vote.
// The first two samples are stored; the third is the live synchronised line,
// so the vote is valid in the same cycle as the deciding tick.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rx,
  input  logic i_sample,
  output logic o_rxs,
  output logic o_vote
);

  logic [1:0] sync_q;
  logic [1:0] samp_q;

  // Bring the asynchronous line into the i_clk domain; idle-high reset value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_rx};
    end
  end

  assign o_rxs = sync_q[1];

  // Capture the early samples of each bit when the FSM requests them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      samp_q <= 2'b00;
    end else if (i_sample) begin
      samp_q <= {samp_q[0], o_rxs};
    end
  end

  assign o_vote = maj3(samp_q[1], samp_q[0], o_rxs);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// start-bit glitch rejection, majority-vote sampling, and parity / framing /
// break error reporting. Results commit at the centre of the last stop bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_rx,
  output logic            o_rx_done,
  output logic            o_parity_err,
  output logic            o_frame_err,
  output logic            o_break
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = 4;
  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_SMP1 = S_W'(OVERSAMPLE - 3);
  localparam logic [S_W-1:0] S_SMP2 = S_W'(OVERSAMPLE - 2);
  localparam logic [N_W-1:0] N_DLAST = N_W'(DBIT - 1);
  localparam logic [N_W-1:0] N_SLAST = N_W'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration time.
  if (DBIT < 5 || DBIT > 9) begin : g_bad_dbit
    $error("uart_rx_param: DBIT must be in 5..9");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  rx_state_e       state_q, state_d;
  logic [S_W-1:0]  s_q, s_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            xor_q, xor_d;
  logic            perr_acc_q, perr_acc_d;
  logic            ferr_acc_q, ferr_acc_d;
  logic            ones_q, ones_d;
  logic [DBIT-1:0] rx_q, rx_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            brk_q, brk_d;

  logic rxs;
  logic vote;
  logic in_bit_state;
  logic sample_en;

  assign in_bit_state = (state_q == ST_DATA) || (state_q == ST_PARITY) ||
                        (state_q == ST_STOP);
  assign sample_en = i_s_tick && in_bit_state && (s_q == S_SMP1 || s_q == S_SMP2);

  uart_rx_sampler u_sampler (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_rx     (i_rx),
    .i_sample (sample_en),
    .o_rxs    (rxs),
    .o_vote   (vote)
  );

  // State, counters, frame accumulators and committed outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      xor_q      <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      ones_q     <= 1'b0;
      rx_q       <= '0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      xor_q      <= xor_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      ones_q     <= ones_d;
      rx_q       <= rx_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  // Next-state logic: frame sequencing, bit decisions and result commit.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    xor_d      = xor_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    ones_d     = ones_q;
    rx_d       = rx_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (i_s_tick) begin
          if (s_q == S_HALF) begin
            if (rxs) begin
              // Line went back high before mid start bit: a glitch.
              state_d = ST_IDLE;
              s_d     = '0;
            end else begin
              state_d    = ST_DATA;
              s_d        = '0;
              n_d        = '0;
              xor_d      = 1'b0;
              perr_acc_d = 1'b0;
              ferr_acc_d = 1'b0;
              ones_d     = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA, ST_PARITY, ST_STOP: begin
        if (i_s_tick) begin
          if (s_q != S_LAST) begin
            s_d = s_q + 1'b1;
          end else begin
            s_d = '0;
            if (state_q == ST_DATA) begin
              b_d    = {vote, b_q[DBIT-1:1]};
              xor_d  = xor_q ^ vote;
              ones_d = ones_q | vote;
              if (n_q == N_DLAST) begin
                n_d     = '0;
                state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                n_d = n_q + 1'b1;
              end
            end else if (state_q == ST_PARITY) begin
              perr_acc_d = (PARITY == PAR_EVEN) ? (xor_q ^ vote) : ~(xor_q ^ vote);
              ones_d     = ones_q | vote;
              n_d        = '0;
              state_d    = ST_STOP;
            end else begin
              ferr_acc_d = ferr_acc_q | ~vote;
              ones_d     = ones_q | vote;
              if (n_q == N_SLAST) begin
                // Centre of the last stop bit: publish the frame.
                n_d     = '0;
                rx_d    = b_q;
                perr_d  = perr_acc_q;
                ferr_d  = ferr_acc_d;
                brk_d   = ferr_acc_d & ~ones_d;
                done_d  = 1'b1;
                state_d = rxs ? ST_IDLE : ST_WAIT_IDLE;
              end else begin
                n_d = n_q + 1'b1;
              end
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  assign o_rx         = rx_q;
  assign o_rx_done    = done_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the UART/MCU datapath. It takes the raw serial line and the shared baud-rate oversampling tick, and delivers one data word per frame with a one-cycle done strobe. Compared with the fixed 8N1 receiver, it adds:
- configurable data width, parity and stop-bit count
- input synchronisation and start-bit glitch rejection
- majority-vote bit sampling
- parity, framing and break error reporting

## Interface
Parameters:
- DBIT, 8: data bits per frame; legal 5..9.
- OVERSAMPLE, 16: i_s_tick pulses per bit period; even, legal >= 8.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset i_reset, asynchronous, active-high; clock i_clk.
- i_rx  in  1  raw serial line, idle high, asynchronous to i_clk.
- i_s_tick  in  1  oversampling tick, one i_clk cycle wide.
- o_rx  out  DBIT  received word, LSB first on the line.
- o_rx_done  out  1  one-cycle strobe: frame complete.
- o_parity_err  out  1  parity mismatch on last frame; always 0 when PARITY=0.
- o_frame_err  out  1  a stop bit sampled 0 on last frame.
- o_break  out  1  entire last frame was 0.

## Operation
- i_rx passes through a 2-FF synchroniser, reset value 1. All logic below uses the synchronised line, rxs.
- State machine: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Counter s counts ticks, width clog2(OVERSAMPLE). Counter n counts bits.
- IDLE: if rxs==0, go to START with s=0. This transition is not gated by i_s_tick.
- START: on each tick, s++. At s==OVERSAMPLE/2-1:
  - if rxs==1, it was a glitch; go to IDLE with no strobe and no flag change.
  - otherwise go to DATA with s=0 and n=0.
- Majority sampling: on ticks at s = OVERSAMPLE-3, -2 and -1, capture rxs. The bit value is the majority of the 3 samples, decided at s==OVERSAMPLE-1, and s then wraps to 0.
- DATA: each decided bit shifts into the word register as {bit, b[DBIT-1:1]}, and a running XOR is updated. After DBIT bits, go to PARITY if PARITY!=0, else to STOP.
- PARITY: decide one bit.
  - even: error if XOR(data, bit)==1.
  - odd: error if XOR(data, bit)==0.
- STOP: decide STOP_BITS bits; any 0 sets the frame error. At the last stop decision, commit the result:
  - o_rx is updated.
  - All three flags are updated.
  - o_rx_done is asserted.
  - Next state is IDLE if rxs is currently 1, else WAIT_IDLE.
- Break: the frame error is set, and every data bit, the parity bit (if present) and every stop bit are 0.
- WAIT_IDLE: stay until rxs==1, then go to IDLE. No new start bit is accepted while in this state.

## Timing
- Reset values:
  - o_rx = 0
  - o_rx_done = 0
  - all flags = 0
  - state = IDLE
  - counters = 0
  - synchroniser = 1
- Registered outputs. o_rx and the flags change on the same edge that raises o_rx_done, and hold until the next commit.
- o_rx_done is high exactly one i_clk cycle per completed frame. It is never asserted for a rejected glitch.
- Input-to-logic latency is 2 i_clk cycles from the synchroniser. The commit happens at the centre of the last stop bit.
- Reset mid-frame: the frame is aborted immediately and no strobe is issued.
- Ticks are ignored in IDLE and WAIT_IDLE.
- If parameters fall outside their legal ranges, elaboration fails with $error.

## Structure
- Package uart_pkg holds:
  - the state enum
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
- Sub-module uart_rx_sampler contains the 2-FF synchroniser and the 3-sample majority register. It outputs rxs and the voted bit.
- The FSM and counters stay in uart_rx_param.

## Test plan
Unless stated otherwise: OVERSAMPLE=16, tick every 4 clk, so one bit period is 64 clk.
- Defaults (8N1), send 0xA5, then 0x00 with a 1-tick high glitch at the centre of bit 3 -> two strobes; o_rx=0xA5 then 0x00; all flags 0.
- PARITY=1, send 0x03 with parity bit 1 -> o_rx=0x03, o_parity_err=1, o_frame_err=0. Resend with parity bit 0 -> o_parity_err=0.
- i_rx low for 3 ticks then high, followed by frame 0x5A -> exactly one strobe, o_rx=0x5A.
- i_rx low for 20 bit periods, then high, then frame 0x81:
  - first strobe: o_rx=0x00, o_frame_err=1, o_break=1
  - no further strobe while the line stays low
  - second strobe: o_rx=0x81, flags 0
- DBIT=7, STOP_BITS=2, send 0x55 with the second stop bit 0 -> o_rx=0x55, o_frame_err=1, o_break=0.
- Pulse i_reset during data bit 4 -> no strobe, o_rx=0. After release, send 0xFF -> o_rx=0xFF.
